uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL provide parameter DEPTH, default 16, number of 8-bit entries (power of two).
REQ-002 SHALL provide port clk  input  1  rising-edge clock.
REQ-003 SHALL provide port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL provide port en  input  1  FIFO enable (FCR[0]); 1 = DEPTH-entry mode, 0 = single-entry holding-register mode.
REQ-005 SHALL provide port clr  input  1  synchronous FIFO flush (FCR[2]).
REQ-006 SHALL provide port push_in  input  1  write strobe from bus interface.
REQ-007 SHALL provide port din  input  8  write data.
REQ-008 SHALL provide port pop_in  input  1  read strobe; connects to the transmitter's pop output.
REQ-009 SHALL provide port threshold  input  2  trigger level select.
REQ-010 SHALL provide port dout  output  8  head-of-queue data; connects to the transmitter's din.
REQ-011 SHALL provide port empty  output  1  no entries; connects to the transmitter's thre.
REQ-012 SHALL provide port full  output  1  no free entry in the current mode.
REQ-013 SHALL provide port overrun  output  1  sticky flag, write attempted while full.
REQ-014 SHALL provide port count  output  5  current occupancy, 0..DEPTH.
REQ-015 SHALL provide port thre_trig  output  1  occupancy at or below trigger level.

Function
REQ-016 SHALL be first-word-fall-through: dout equals the oldest entry combinationally; dout is don't-care while empty=1.
REQ-017 SHALL write din at the write pointer on a clk edge with push_in=1 and full=0, then increment the write pointer modulo DEPTH.
REQ-018 SHALL advance the read pointer modulo DEPTH on a clk edge with pop_in=1 and empty=0.
REQ-019 SHALL ignore pop_in while empty=1: pointers, count and flags unchanged.
REQ-020 SHALL drop push_in while full=1 without a simultaneous accepted pop, set overrun on that edge, and leave memory unchanged.
REQ-021 SHALL, with push_in=1 and pop_in=1 on the same edge and 0<count<capacity, perform both, leaving count unchanged.
REQ-022 SHALL, with push_in=1 and pop_in=1 while full, perform both (pop frees the slot), count unchanged, and not set overrun.
REQ-023 SHALL, with push_in=1 and pop_in=1 while empty, perform only the push; count becomes 1.
REQ-024 SHALL drive empty = (count==0) and full = (count==DEPTH) when en=1, and full = (count==1) when en=0.
REQ-025 SHALL, on any edge where en changes value, flush as per REQ-026 in addition to the mode change.
REQ-026 SHALL, on a clk edge with clr=1, zero both pointers and count and clear overrun; clr overrides push_in and pop_in on that edge; memory contents are not cleared.
REQ-027 SHALL keep overrun set until clr, an en change, or reset.
REQ-028 SHALL register count, both pointers and overrun; full, empty and thre_trig are combinational from count and en.

Reset
REQ-029 SHALL, on a clk edge with rst=0, set pointers=0, count=0, overrun=0, hence empty=1, full=0, thre_trig=1; rst has priority over clr, push_in and pop_in.
REQ-030 SHALL abandon a transfer in progress on reset; entries are lost, and dout is don't-care until the next push.

Configuration
REQ-031 SHALL use macro UART_TXFIFO_TRIG_EN to compile in the programmable trigger.
REQ-032 SHALL, with UART_TXFIFO_TRIG_EN defined, drive thre_trig = (count <= L), L = 0, 2, 4, 8 for threshold 00, 01, 10, 11; with en=0, L is forced to 0.
REQ-033 SHALL, without UART_TXFIFO_TRIG_EN, ignore threshold and drive thre_trig = empty.

Verification
REQ-034 SHALL cover: en=1, push 0x13, 0x27, 0x41 on consecutive cycles, then pop three times -> dout reads 0x13, 0x27, 0x41 in order; count 3->0; empty=1.
REQ-035 SHALL cover: en=1, push 17 bytes with no pop -> full=1 after the 16th; 17th dropped; overrun=1; count=16; the first pop returns byte 1.
REQ-036 SHALL cover: en=1, fill 16, then simultaneous push 0xAA and pop for 16 cycles -> count stays 16, overrun stays 0, pointers wrap, and the last 16 pops return 0xAA.
REQ-037 SHALL cover: en=0, push 0x55 then push 0x66 -> full=1 after the first, 0x66 dropped, overrun=1, dout=0x55.
REQ-038 SHALL cover: count=5, clr=1 with push_in=1 on the same edge -> count=0, empty=1, overrun=0; rst=0 mid-fill -> same state, thre_trig=1.
REQ-039 SHALL cover, with UART_TXFIFO_TRIG_EN defined, threshold=10, draining from 6 -> thre_trig rises when count reaches 4; without the macro, thre_trig tracks empty.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmit FIFO, first-word-fall-through; optional trigger level via `UART_TXFIFO_TRIG_EN.
// Latency: a pushed byte is visible on dout the cycle after the push edge; flags are combinational from count.
// Backpressure: full refuses further pushes (sticky overrun); pops while empty are ignored.
module uart_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic       push_in,
    input  logic [7:0] din,
    input  logic       pop_in,
    input  logic [1:0] threshold,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full,
    output logic       overrun,
    output logic [4:0] count,
    output logic       thre_trig
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_C = 5'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]    count_q, count_d;
    logic          overrun_q, overrun_d;
    logic          en_q;

    logic       flush;
    logic       do_push;
    logic       do_pop;
    logic [4:0] capacity;

    assign capacity = en ? DEPTH_C : 5'd1;
    assign empty    = (count_q == 5'd0);
    assign full     = (count_q == capacity);
    assign count    = count_q;
    assign overrun  = overrun_q;
    assign dout     = mem_q[rd_ptr_q];

    // A mode change flushes exactly like clr, so stale entries never straddle modes.
    assign flush   = clr | (en != en_q);
    assign do_pop  = pop_in & ~empty;
    assign do_push = push_in & (~full | do_pop);

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        if (flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = 5'd0;
            overrun_d = 1'b0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push && !do_pop) count_d = count_q + 5'd1;
            else if (do_pop && !do_push) count_d = count_q - 5'd1;
            if (push_in && !do_push) overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= 5'd0;
            overrun_q <= 1'b0;
            en_q      <= en;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            en_q      <= en;
        end
    end

    // Storage is deliberately not reset or flushed; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (rst && !flush && do_push) mem_q[wr_ptr_q] <= din;
    end

`ifdef UART_TXFIFO_TRIG_EN
    logic [4:0] trig_lvl;

    always_comb begin
        trig_lvl = 5'd0;
        if (en) begin
            case (threshold)
                2'b01:   trig_lvl = 5'd2;
                2'b10:   trig_lvl = 5'd4;
                2'b11:   trig_lvl = 5'd8;
                default: trig_lvl = 5'd0;
            endcase
        end
    end

    assign thre_trig = (count_q <= trig_lvl);
`else
    logic unused_threshold;

    assign unused_threshold = ^threshold;
    assign thre_trig        = empty;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized and directed checks of uart_tx_fifo against a queue-based reference model.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       clr;
    logic       push_in;
    logic [7:0] din;
    logic       pop_in;
    logic [1:0] threshold;
    logic [7:0] dout;
    logic       empty;
    logic       full;
    logic       overrun;
    logic [4:0] count;
    logic       thre_trig;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mq [$];
    bit         m_ovr;
    logic       m_en_prev;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DEPTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clr       (clr),
        .push_in   (push_in),
        .din       (din),
        .pop_in    (pop_in),
        .threshold (threshold),
        .dout      (dout),
        .empty     (empty),
        .full      (full),
        .overrun   (overrun),
        .count     (count),
        .thre_trig (thre_trig)
    );

    // Reference: a byte queue bounded by the mode's capacity plus a sticky overrun bit.
    task automatic model_update();
        int  cap;
        bit  can_pop;
        bit  can_push;
        if (!rst || clr || (en !== m_en_prev)) begin
            mq.delete();
            m_ovr = 0;
        end else begin
            cap      = en ? 16 : 1;
            can_pop  = pop_in && (mq.size() > 0);
            can_push = push_in && ((mq.size() < cap) || can_pop);
            if (push_in && !can_push) m_ovr = 1;
            if (can_pop) void'(mq.pop_front());
            if (can_push) mq.push_back(din);
        end
        m_en_prev = en;
    endtask

    function automatic bit m_trig();
        int lvl;
        lvl = 0;
        if (en) begin
            case (threshold)
                2'd1:    lvl = 2;
                2'd2:    lvl = 4;
                2'd3:    lvl = 8;
                default: lvl = 0;
            endcase
        end
`ifdef UART_TXFIFO_TRIG_EN
        return mq.size() <= lvl;
`else
        return mq.size() == 0;
`endif
    endfunction

    task automatic step(input logic p, input logic [7:0] d, input logic po, input logic c);
        push_in = p;
        din     = d;
        pop_in  = po;
        clr     = c;
        @(posedge clk);
        model_update();
        #1;
        push_in = 1'b0;
        pop_in  = 1'b0;
        clr     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b1;
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        checks++; if (thre_trig !== 1'b1) begin failures++; $display("FAIL reset_thre_trig got=%b exp=1", thre_trig); end
    endtask

    task automatic test_basic_order();
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h13; exp_b[1] = 8'h27; exp_b[2] = 8'h41;
        en = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, exp_b[i], 1'b0, 1'b0);
        checks++; if (count !== 5'd3) begin failures++; $display("FAIL basic_count3 got=%0d exp=3", count); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (dout !== exp_b[i]) begin failures++; $display("FAIL basic_dout%0d got=%h exp=%h", i, dout, exp_b[i]); end
            step(1'b0, 8'h00, 1'b1, 1'b0);
            checks++; if (count !== 5'(2 - i)) begin failures++; $display("FAIL basic_count got=%0d exp=%0d", count, 2 - i); end
        end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL basic_empty got=%b exp=1", empty); end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (count !== 5'd0 || empty !== 1'b1) begin failures++; $display("FAIL pop_on_empty count=%0d empty=%b exp=0/1", count, empty); end
    endtask

    task automatic test_overflow();
        en = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 1; i <= 17; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            if (i == 15) begin
                checks++; if (full !== 1'b0) begin failures++; $display("FAIL ovf_full15 got=%b exp=0", full); end
            end
            if (i == 16) begin
                checks++; if (full !== 1'b1) begin failures++; $display("FAIL ovf_full16 got=%b exp=1", full); end
                checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovf_overrun16 got=%b exp=0", overrun); end
            end
        end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovf_overrun got=%b exp=1", overrun); end
        checks++; if (count !== 5'd16) begin failures++; $display("FAIL ovf_count got=%0d exp=16", count); end
        checks++; if (dout !== 8'd1) begin failures++; $display("FAIL ovf_first_pop got=%h exp=01", dout); end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (overrun !== 1'b1 || dout !== 8'd2) begin failures++; $display("FAIL ovf_sticky overrun=%b dout=%h exp=1/02", overrun, dout); end
    endtask

    task automatic test_back_to_back_full();
        logic [7:0] fill [16];
        en = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            fill[i] = 8'($urandom_range(0, 255));
            step(1'b1, fill[i], 1'b0, 1'b0);
        end
        for (int i = 0; i < 16; i++) begin
            checks++; if (dout !== fill[i]) begin failures++; $display("FAIL b2b_old%0d got=%h exp=%h", i, dout, fill[i]); end
            step(1'b1, 8'hAA, 1'b1, 1'b0);
            checks++; if (count !== 5'd16 || overrun !== 1'b0) begin failures++; $display("FAIL b2b_state%0d count=%0d overrun=%b exp=16/0", i, count, overrun); end
        end
        for (int i = 0; i < 16; i++) begin
            checks++; if (dout !== 8'hAA) begin failures++; $display("FAIL b2b_new%0d got=%h exp=aa", i, dout); end
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL b2b_empty got=%b exp=1", empty); end
        step(1'b1, 8'h5C, 1'b1, 1'b0);
        checks++; if (count !== 5'd1 || dout !== 8'h5C) begin failures++; $display("FAIL push_pop_empty count=%0d dout=%h exp=1/5c", count, dout); end
    endtask

    task automatic test_single_mode();
        en = 1'b0;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL single_flush got=%0d exp=0", count); end
        step(1'b1, 8'h55, 1'b0, 1'b0);
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL single_full got=%b exp=1", full); end
        step(1'b1, 8'h66, 1'b0, 1'b0);
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL single_overrun got=%b exp=1", overrun); end
        checks++; if (dout !== 8'h55 || count !== 5'd1) begin failures++; $display("FAIL single_dout dout=%h count=%0d exp=55/1", dout, count); end
        en = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        checks++; if (count !== 5'd0 || overrun !== 1'b0) begin failures++; $display("FAIL en_change count=%0d overrun=%b exp=0/0", count, overrun); end
    endtask

    task automatic test_clr_and_reset();
        en = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        checks++; if (count !== 5'd5) begin failures++; $display("FAIL clr_pre got=%0d exp=5", count); end
        step(1'b1, 8'hEE, 1'b0, 1'b1);
        checks++; if (count !== 5'd0 || empty !== 1'b1 || overrun !== 1'b0) begin failures++; $display("FAIL clr_push count=%0d empty=%b overrun=%b exp=0/1/0", count, empty, overrun); end
        for (int i = 0; i < 3; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        rst = 1'b0;
        step(1'b1, 8'h77, 1'b1, 1'b0);
        rst = 1'b1;
        checks++; if (count !== 5'd0 || empty !== 1'b1 || thre_trig !== 1'b1 || overrun !== 1'b0) begin failures++; $display("FAIL rst_midfill count=%0d empty=%b trig=%b overrun=%b exp=0/1/1/0", count, empty, thre_trig, overrun); end
    endtask

    task automatic test_trigger();
        bit exp_t;
        en        = 1'b1;
        threshold = 2'b10;
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        for (int rem = 6; rem >= 0; rem--) begin
`ifdef UART_TXFIFO_TRIG_EN
            exp_t = (rem <= 4);
`else
            exp_t = (rem == 0);
`endif
            checks++; if (thre_trig !== exp_t) begin failures++; $display("FAIL trig_rem%0d got=%b exp=%b", rem, thre_trig, exp_t); end
            if (rem > 0) step(1'b0, 8'h00, 1'b1, 1'b0);
        end
    endtask

    task automatic test_random();
        int cap;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 199) == 0) en = ~en;
            if ($urandom_range(0, 49) == 0) threshold = 2'($urandom_range(0, 3));
            rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            step(1'($urandom_range(0, 99) < 55), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 149) == 0));
            rst = 1'b1;
            cap = en ? 16 : 1;
            checks++;
            if (count !== 5'(mq.size()) || empty !== (mq.size() == 0) || full !== (mq.size() == cap)
                || overrun !== m_ovr || thre_trig !== m_trig()
                || (mq.size() > 0 && dout !== mq[0])) begin
                failures++;
                $display("FAIL rand%0d count=%0d/%0d empty=%b full=%b ovr=%b/%b trig=%b/%b dout=%h",
                         cyc, count, mq.size(), empty, full, overrun, m_ovr, thre_trig, m_trig(), dout);
            end
        end
    endtask

    initial begin
        rst       = 1'b0;
        en        = 1'b1;
        clr       = 1'b0;
        push_in   = 1'b0;
        pop_in    = 1'b0;
        din       = 8'h00;
        threshold = 2'b00;
        m_en_prev = 1'b1;
        m_ovr     = 0;
        test_reset();
        test_basic_order();
        test_overflow();
        test_back_to_back_full();
        test_single_mode();
        test_clr_and_reset();
        test_trigger();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
